// File: rtl/fa_serial_ctrl.sv
// -----------------------------------------------------------------------------
// fa_serial_ctrl
//
// Bit-serial adder controller. A single one-bit full-adder slice is time-shared
// to add two WIDTH-bit operands, one bit per clock, LSB first.
//
//   s  = x ^ y ^ c
//   co = x&y | y&c | x&c
//
// A requester pulses start while the block is idle, waits for the one-cycle
// done pulse, then reads sum/cout. sum/cout hold the last completed result
// until the next completion or reset. Partial results are never visible.
//
// Timing (WIDTH=8): start accepted at edge 0 -> busy for WIDTH cycles -> done
// for one cycle -> idle. Back-to-back operations take WIDTH+2 cycles.
//
// Parameters:
//   WIDTH  operand/result width in bits, legal range 2..32
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only while idle
//   a, b   operands, captured on an accepted start
//   cin    carry-in, captured on an accepted start
//   sub    (SERIAL_SUB_EN only) subtract request, captured with start
//   busy   high while the serial add is running
//   done   one-cycle pulse, sum/cout valid from this cycle on
//   sum    last completed sum
//   cout   last completed carry-out (in subtract mode: 1 = no borrow)
//
// Configuration macro:
//   SERIAL_SUB_EN  when defined, adds the sub port and a subtract mode that
//                  computes a - b as a + ~b + 1. Undefined: add-only.
// -----------------------------------------------------------------------------
module fa_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter wide enough to hold WIDTH-1 with headroom; it never passes WIDTH-1.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;      // operand A shift register, LSB is the live bit
  logic [WIDTH-1:0] sb;      // operand B (or ~B) shift register
  logic [WIDTH-1:0] ps;      // partial sum, filled from the MSB end
  logic             carry;   // carry between successive slice evaluations
  logic [CW-1:0]    cnt;     // index of the bit being added this cycle

  // Shared one-bit full-adder slice.
  logic slice_s;
  logic slice_co;

  // Values loaded into the datapath when a start is accepted.
  logic [WIDTH-1:0] load_b;
  logic             load_c;

  // NOTE: combinational blocks use blocking assignments and give every output
  // a value on every path, so no latch can be inferred.
  always_comb begin
    slice_s  = sa[0] ^ sb[0] ^ carry;
    slice_co = (sa[0] & sb[0]) | (sb[0] & carry) | (sa[0] & carry);
  end

  always_comb begin
    load_b = b;
    load_c = cin;
`ifdef SERIAL_SUB_EN
    // Two's-complement subtract: a - b = a + ~b + 1, so the carry-in is forced.
    if (sub) begin
      load_b = ~b;
      load_c = 1'b1;
    end
`endif
  end

  // Whole controller in one clocked block: state, datapath and registered
  // outputs move together, so busy/done always match the state they describe.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register here is a small flop bank, not a memory array,
      // so all of it is reset; an aborted operation leaves nothing behind.
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      ps    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= load_b;
            carry <= load_c;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end

        RUN: begin
          // Sum bit enters at the MSB; after WIDTH shifts bit 0 of the
          // operands has reached bit 0 of ps.
          ps    <= {slice_s, ps[WIDTH-1:1]};
          sa    <= {1'b0, sa[WIDTH-1:1]};
          sb    <= {1'b0, sb[WIDTH-1:1]};
          carry <= slice_co;
          if (cnt == LAST) begin
            // Publish including the bit computed this cycle; cnt is parked at
            // zero so it never exceeds WIDTH-1.
            sum   <= {slice_s, ps[WIDTH-1:1]};
            cout  <= slice_co;
            cnt   <= '0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          // Unconditional: start is not looked at here, so done is one cycle.
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fa_serial_ctrl
//
// Self-checking bench for fa_serial_ctrl (WIDTH=8). Expected results come from
// whole-word arithmetic: {cout,sum} = a + b + cin, or for subtract
// sum = (a - b) mod 2^8 with cout = (a >= b). Inputs are driven and outputs
// sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fa_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fa_serial_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Reference: full-width arithmetic, result as {cout, sum}.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    logic [W:0] r;
    if (s) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from idle and observes it to completion. busy_n counts
  // busy cycles, done_at is the cycle index of done (-1 on timeout), and
  // done_after is done one cycle later.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input logic s, output logic [W:0] exp,
                        output int busy_n, output int done_at,
                        output logic [W-1:0] r_sum, output logic r_cout,
                        output logic done_after);
    exp   = model(x, y, c, s);
    a     = x;
    b     = y;
    cin   = c;
`ifdef SERIAL_SUB_EN
    sub   = s;
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    a     = ~x;       // later operand changes must have no effect
    b     = ~y;
    cin   = ~c;
    busy_n     = 0;
    done_at    = -1;
    r_sum      = 'x;
    r_cout     = 1'bx;
    done_after = 1'bx;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_at = i;
        r_sum   = sum;
        r_cout  = cout;
        break;
      end
      step();
    end
    step();
    done_after = done;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;    // reset must win over start
    a     = 8'hA5;
    b     = 8'h5A;
    cin   = 1'b1;
`ifdef SERIAL_SUB_EN
    sub   = 1'b0;
`endif
    step();
    step();
    n_tests++;
    if ({busy, done, cout, sum} !== {3'b000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b done=%b cout=%b sum=%h, want 0 0 0 00",
               busy, done, cout, sum);
    end
    rst   = 1'b0;
    start = 1'b0;
    step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_ignored: busy=%b want 0", busy);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [5] = '{8'h35, 8'hFF, 8'hFF, 8'h00, 8'h80};
    logic [W-1:0] vb [5] = '{8'h1A, 8'h01, 8'hFF, 8'h00, 8'h7F};
    logic         vc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W:0]   exp;
    int           busy_n, done_at;
    logic [W-1:0] r_sum;
    logic         r_cout, done_after;
    for (int k = 0; k < 5; k++) begin
      run_op(va[k], vb[k], vc[k], 1'b0, exp, busy_n, done_at, r_sum, r_cout, done_after);
      n_tests++;
      if (busy_n !== W || done_at !== W || done_after !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_timing[%0d]: busy_cycles=%0d done_at=%0d done_after=%b, want %0d %0d 0",
                 k, busy_n, done_at, done_after, W, W);
      end
      n_tests++;
      if ({r_cout, r_sum} !== exp) begin
        n_fail++;
        $display("FAIL directed_result[%0d] %h+%h+%b: got cout=%b sum=%h, want cout=%b sum=%h",
                 k, va[k], vb[k], vc[k], r_cout, r_sum, exp[W], exp[W-1:0]);
      end
    end
    // First vector is the documented one: 0x35 + 0x1A = 0x4F.
    n_tests++;
    if (model(8'h35, 8'h1A, 1'b0, 1'b0) !== {1'b0, 8'h4F} ||
        model(8'hFF, 8'hFF, 1'b1, 1'b0) !== {1'b1, 8'hFF}) begin
      n_fail++;
      $display("FAIL model_sanity: reference model disagrees with documented values");
    end
  endtask

  task automatic test_ignore_start();
    int           dones = 0;
    int           busy_n = 0;
    logic [W-1:0] r_sum = '0;
    logic         r_cout = 1'b0;
    a     = 8'h01;
    b     = 8'h01;
    cin   = 1'b0;
`ifdef SERIAL_SUB_EN
    sub   = 1'b0;
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (i == 3) begin
        a     = 8'h80;
        b     = 8'h80;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_n++;
      if (done) begin
        dones++;
        r_sum  = sum;
        r_cout = cout;
      end
      step();
    end
    start = 1'b0;
    n_tests++;
    if (dones !== 1 || busy_n !== W) begin
      n_fail++;
      $display("FAIL ignore_start_count: dones=%0d busy_cycles=%0d, want 1 %0d", dones, busy_n, W);
    end
    n_tests++;
    if ({r_cout, r_sum} !== {1'b0, 8'h02}) begin
      n_fail++;
      $display("FAIL ignore_start_result: cout=%b sum=%h, want 0 02", r_cout, r_sum);
    end
  endtask

  task automatic test_abort();
    int           seen = 0;
    logic [W:0]   exp;
    int           busy_n, done_at;
    logic [W-1:0] r_sum;
    logic         r_cout, done_after;
    a     = 8'h35;
    b     = 8'h1A;
    cin   = 1'b0;
`ifdef SERIAL_SUB_EN
    sub   = 1'b0;
`endif
    start = 1'b1;
    step();            // accepted; now in RUN cycle 1
    start = 1'b0;
    step();
    step();
    step();            // RUN cycle 4
    rst = 1'b1;
    step();
    n_tests++;
    if ({busy, done, cout, sum} !== {3'b000, 8'h00}) begin
      n_fail++;
      $display("FAIL abort_reset: busy=%b done=%b cout=%b sum=%h, want 0 0 0 00",
               busy, done, cout, sum);
    end
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) seen++;
      step();
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: active_cycles=%0d want 0", seen);
    end
    run_op(8'h10, 8'h20, 1'b0, 1'b0, exp, busy_n, done_at, r_sum, r_cout, done_after);
    n_tests++;
    if (done_at !== W || {r_cout, r_sum} !== {1'b0, 8'h30}) begin
      n_fail++;
      $display("FAIL abort_recover: done_at=%0d cout=%b sum=%h, want %0d 0 30",
               done_at, r_cout, r_sum, W);
    end
  endtask

  // start held high: an operation is accepted every W+2 edges. Operands are
  // re-randomised every cycle; only those present at an accepting edge count.
  task automatic test_back_to_back();
    localparam int P = W + 2;
    localparam int N = 5;
    logic [W-1:0] xa [N*P];
    logic [W-1:0] xb [N*P];
    logic         xc [N*P];
    logic [W:0]   exp = '0;
    logic [W-1:0] held = '0;
    int           errs = 0;
    int           dones = 0;
    xa[0] = W'($urandom);
    xb[0] = W'($urandom);
    xc[0] = 1'($urandom);
    a     = xa[0];
    b     = xb[0];
    cin   = xc[0];
`ifdef SERIAL_SUB_EN
    sub   = 1'b0;
`endif
    start = 1'b1;
    for (int k = 0; k < N*P; k++) begin
      step();          // now just after edge k
      if ((k % P) == W) begin
        exp = model(xa[k - W], xb[k - W], xc[k - W], 1'b0);
        dones++;
        if (done !== 1'b1 || {cout, sum} !== exp) begin
          errs++;
          $display("FAIL b2b_result edge %0d: done=%b cout=%b sum=%h, want 1 %b %h",
                   k, done, cout, sum, exp[W], exp[W-1:0]);
        end
        held = sum;
      end else begin
        if (done !== 1'b0 || busy !== ((k % P) < W) || (k > W && sum !== held)) begin
          errs++;
          $display("FAIL b2b_idle edge %0d: done=%b busy=%b sum=%h held=%h",
                   k, done, busy, sum, held);
        end
      end
      if (k + 1 < N*P) begin
        xa[k+1] = W'($urandom);
        xb[k+1] = W'($urandom);
        xc[k+1] = 1'($urandom);
        a       = xa[k+1];
        b       = xb[k+1];
        cin     = xc[k+1];
      end
      if (k == N*P - 2) start = 1'b0;
    end
    start = 1'b0;
    n_tests++;
    if (errs !== 0 || dones !== N) begin
      n_fail++;
      $display("FAIL b2b_summary: cycle_errors=%0d ops=%0d, want 0 %0d", errs, dones, N);
    end
  endtask

  task automatic test_random();
    logic [W:0]   exp;
    int           busy_n, done_at;
    logic [W-1:0] r_sum, x, y;
    logic         r_cout, done_after, c, s;
    for (int k = 0; k < 30; k++) begin
      x = W'($urandom);
      y = W'($urandom);
      c = 1'($urandom);
`ifdef SERIAL_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      run_op(x, y, c, s, exp, busy_n, done_at, r_sum, r_cout, done_after);
      n_tests++;
      if (done_at !== W || busy_n !== W || {r_cout, r_sum} !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] a=%h b=%h cin=%b sub=%b: done_at=%0d busy=%0d cout=%b sum=%h, want %0d %0d %b %h",
                 k, x, y, c, s, done_at, busy_n, r_cout, r_sum, W, W, exp[W], exp[W-1:0]);
      end
    end
  endtask

`ifdef SERIAL_SUB_EN
  task automatic test_sub();
    logic [W-1:0] va [2]  = '{8'h10, 8'h03};
    logic [W-1:0] vb [2]  = '{8'h03, 8'h10};
    logic [W:0]   want [2] = '{{1'b1, 8'h0D}, {1'b0, 8'hF3}};
    logic [W:0]   exp;
    int           busy_n, done_at;
    logic [W-1:0] r_sum;
    logic         r_cout, done_after;
    for (int k = 0; k < 2; k++) begin
      run_op(va[k], vb[k], 1'b0, 1'b1, exp, busy_n, done_at, r_sum, r_cout, done_after);
      n_tests++;
      if (done_at !== W || {r_cout, r_sum} !== want[k]) begin
        n_fail++;
        $display("FAIL sub[%0d] %h-%h: done_at=%0d cout=%b sum=%h, want %0d %b %h",
                 k, va[k], vb[k], done_at, r_cout, r_sum, W, want[k][W], want[k][W-1:0]);
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
`ifdef SERIAL_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
